// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam int unsigned BCD_MAX  = 9;
    localparam int unsigned BCD_CORR = 6;
    localparam int unsigned SEG_W    = 7;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // True when a nibble is not a legal BCD digit.
    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'(BCD_MAX);
    endfunction

    // Seven-segment pattern for one BCD digit; non-BCD codes blank.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] d);
        logic [SEG_W-1:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] raw;
    logic [4:0] adj;

    assign raw = 5'(a) + 5'(b) + 5'(ci);
    assign adj = raw + 5'(BCD_CORR);

    // Add 6 when the binary digit sum leaves the decimal range.
    always_comb begin
        s  = raw[3:0];
        co = 1'b0;
        if (raw > 5'(BCD_MAX)) begin
            s  = adj[3:0];
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_add_seq.sv
// Multi-digit BCD adder that time-shares one digit adder, LSD first.
// Optional seven-segment output enabled by defining BCD_ADD_SEQ_HEX_EN.
module bcd_add_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*DIGITS-1:0]   sum_bcd,
    output logic                  cout
`ifdef BCD_ADD_SEQ_HEX_EN
    ,
    output logic [7*(DIGITS+1)-1:0] hex_n
`endif
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t           state, state_nxt;
    logic [W-1:0]     a_q, a_nxt;
    logic [W-1:0]     b_q, b_nxt;
    logic             carry_q, carry_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [W-1:0]     sum_nxt;
    logic             cout_nxt, err_nxt, busy_nxt, done_nxt;
    logic             load_bad;
    logic [3:0]       dig_a, dig_b, dig_s;
    logic             dig_c;

    assign dig_a = a_q[4*int'(idx_q) +: 4];
    assign dig_b = b_q[4*int'(idx_q) +: 4];

    bcd_digit_add u_digit_add (
        .a  (dig_a),
        .b  (dig_b),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_c)
    );

    // Scan every captured operand digit for non-BCD codes.
    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_bad = load_bad | digit_bad(a_q[4*i +: 4]) | digit_bad(b_q[4*i +: 4]);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        carry_nxt = carry_q;
        idx_nxt   = idx_q;
        sum_nxt   = sum_bcd;
        cout_nxt  = cout;
        err_nxt   = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                    a_nxt     = a_bcd;
                    b_nxt     = b_bcd;
                    carry_nxt = cin;
                    idx_nxt   = '0;
                    sum_nxt   = '0;
                    cout_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_bad) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_nxt[4*int'(idx_q) +: 4] = dig_s;
                carry_nxt                   = dig_c;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    cout_nxt  = dig_c;
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_LOAD) || (state_nxt == ST_ADD);
        done_nxt = (state_nxt == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_bcd <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            carry_q <= carry_nxt;
            idx_q   <= idx_nxt;
            sum_bcd <= sum_nxt;
            cout    <= cout_nxt;
            err     <= err_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

`ifdef BCD_ADD_SEQ_HEX_EN
    localparam int unsigned HEX_W = 7 * (DIGITS + 1);

    // Display image of a result: sum digits plus a "1"/blank carry digit.
    function automatic logic [HEX_W-1:0] hex_encode(input logic [W-1:0] s,
                                                    input logic c,
                                                    input logic e);
        logic [HEX_W-1:0] h;
        h = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            h[7*i +: 7] = e ? SEG_BLANK : seg_encode(s[4*i +: 4]);
        end
        h[7*DIGITS +: 7] = (c && !e) ? SEG_1 : SEG_BLANK;
        return h;
    endfunction

    // Segment register tracks the same next values as sum_bcd/cout.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            hex_n <= hex_encode('0, 1'b0, 1'b0);
        end else begin
            hex_n <= hex_encode(sum_nxt, cout_nxt, err_nxt);
        end
    end
`endif

endmodule

// File: doc/bcd_add_seq.md
# bcd_add_seq

Sequencer that shares one registered-free 4-bit BCD digit adder across a multi-digit addition, one digit per clock, least-significant digit first. It sits between the board switch/key inputs and the LEDR/HEX outputs and replaces the purely combinational 4-bit adders as the arithmetic core of the lab top level. A start pulse launches an operation, `busy` covers it, and `done` marks it finished. Invalid BCD operands are flagged rather than added.

## Interface
- `DIGITS`, default 2: BCD digits per operand; legal range 1..8.
- `CLOCK_50  in  1`: sole clock, rising edge.
- `RST_N  in  1`: reset, asynchronous, active-low; clears all state.
- `start  in  1`: single-cycle request pulse, synchronous to `CLOCK_50`.
- `a_bcd  in  4*DIGITS`: operand A; digit i occupies bits [4i+3:4i].
- `b_bcd  in  4*DIGITS`: operand B; same layout as A.
- `cin  in  1`: carry into digit 0.
- `busy  out  1`: high from the LOAD state through the last ADD cycle.
- `done  out  1`: one-cycle pulse in the DONE state.
- `err  out  1`: sticky until next accepted start; set when any operand digit is >9.
- `sum_bcd  out  4*DIGITS`: registered BCD result, stable from `done` until the next accepted start.
- `cout  out  1`: registered decimal carry out of the top digit.
- `hex_n  out  7*(DIGITS+1)`: active-low segments (gfedcba); present only with `BCD_ADD_SEQ_HEX_EN`.

## Operation
- FSM states: IDLE, LOAD, ADD, DONE. Reset state is IDLE.
- IDLE: `busy`=0. If `start`=1, go to LOAD. Otherwise hold.
- LOAD:
  - Capture `a_bcd`, `b_bcd` and `cin` into internal registers. Set the digit index to 0 and the carry to `cin`. Clear `sum_bcd`, `cout` and `err`.
  - If any captured digit is >9, set `err`=1 and go to DONE.
  - Otherwise go to ADD.
- ADD, once per cycle:
  - Compute s = a[idx] + b[idx] + carry as a 5-bit value.
  - If s>9: write s+6 (low 4 bits) to digit idx and set the carry to 1. Otherwise write s and set the carry to 0.
  - If idx==DIGITS-1: `cout` takes the new carry and the FSM goes to DONE. Otherwise increment idx.
- DONE: `done`=1 for this single cycle, then go to IDLE.
- `start` is ignored in every state except IDLE. No request queuing.
- With `err`=1, `sum_bcd`=0 and `cout`=0.
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `err`=0, `sum_bcd`=0, `cout`=0, all internal registers 0. With the HEX option, `hex_n` shows "0" on every sum digit and blank on the carry digit.
- Reset asserted mid-operation aborts immediately to the reset values. No `done` is produced.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: LOAD; `busy`=1.
- Cycles 2..DIGITS+1: ADD.
- Cycle DIGITS+2: DONE, with `done`=1 and the final `sum_bcd`/`cout` visible.
- Latency from `start` to `done` is DIGITS+2 cycles. For DIGITS=2 that is 4.
- Error path: `done` at cycle 2.
- The earliest next accepted `start` is the cycle after DONE.
- `sum_bcd` digits update one per cycle during ADD. Downstream logic samples only on `done`.

## Configuration
- `BCD_ADD_SEQ_HEX_EN` defined:
  - Adds `hex_n`, registered and updated in the same cycle as `sum_bcd`/`cout`.
  - Digit encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
  - Top display digit shows "1" when `cout`=1 and blank otherwise.
  - All digits show blank when `err`=1.
- Not defined: no `hex_n` port and no decode logic. All other behaviour is identical.

## Structure
- Shared package `bcd_pkg` holds:
  - FSM state enum (IDLE, LOAD, ADD, DONE).
  - BCD limit constant 9 and correction constant 6.
  - The seven-segment encoding constants, including blank.
- One sub-module, `bcd_digit_add`: combinational; inputs 4-bit a, 4-bit b, carry-in; outputs corrected 4-bit digit and carry-out. It is instantiated exactly once and time-shared by the FSM.

## Test plan
- DIGITS=2: a=0x45, b=0x38, cin=0, pulse `start` → `done` 4 cycles later, `sum_bcd`=0x83, `cout`=0, `err`=0.
- a=0x99, b=0x99, cin=1 → `sum_bcd`=0x99, `cout`=1.
- a=0x0A, b=0x01 → `done` 2 cycles after `start`, `err`=1, `sum_bcd`=0x00, `cout`=0. Next start with a=0x01, b=0x01 → `err`=0, `sum_bcd`=0x02.
- a=0x12, b=0x34; pulse `start` again one cycle after the first start (during LOAD) → that second pulse is ignored, exactly one `done`, `sum_bcd`=0x46.
- Deassert `RST_N` in the first ADD cycle → all outputs 0 the same cycle, no `done` ever appears. After release, a=0x05, b=0x05 → `sum_bcd`=0x10.
- `BCD_ADD_SEQ_HEX_EN`: a=0x50, b=0x50 → `sum_bcd`=0x00, `cout`=1, `hex_n`={1111001, 1000000, 1000000}.
